// File: rtl/mm_pkg.sv
// Shared definitions for the main-memory controller: FSM state encoding and
// default geometry/latency of the backing store.
package mm_pkg;

    localparam int MM_ADDR_W  = 8;
    localparam int MM_DATA_W  = 8;
    localparam int MM_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } mm_state_e;

endpackage : mm_pkg

// File: rtl/mm_array.sv
// Single-port synchronous RAM backing the data cache; read data is registered
// and reflects the contents before a same-cycle write.
module mm_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset; clearing it would need a write
    // per word, so contents are simply undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule : mm_array

// File: rtl/main_mem_ctrl.sv
// Backing-store controller: serialises an optional write-back and an optional
// refill against mm_array, each phase taking MM_LATENCY cycles.
module main_mem_ctrl #(
    parameter int MM_ADDR_W  = mm_pkg::MM_ADDR_W,
    parameter int MM_DATA_W  = mm_pkg::MM_DATA_W,
    parameter int MM_LATENCY = mm_pkg::MM_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 MMStart,
    input  logic                 MMWrite,
    input  logic                 MMRead,
    input  logic [MM_DATA_W-1:0] OldTag,
    input  logic [MM_DATA_W-1:0] CachetoMem,
    input  logic [MM_ADDR_W-1:0] ABUS,
    output logic [MM_DATA_W-1:0] MemtoCache,
    output logic                 MMBusy,
    output logic                 MMDone
);

    import mm_pkg::*;

    localparam int              CNT_W    = $clog2(MM_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MM_LATENCY - 1);

    mm_state_e state, next_state;

    logic [CNT_W-1:0]     cnt;
    logic [MM_DATA_W-1:0] tag_q;
    logic [MM_DATA_W-1:0] wdata_q;
    logic [MM_ADDR_W-1:0] abus_q;
    logic                 write_q;
    logic                 read_q;

    logic                 accept;
    logic                 phase_last;
    logic                 phase_entry;
    logic                 ram_we;
    logic [MM_ADDR_W-1:0] ram_addr;
    logic [MM_DATA_W-1:0] ram_rdata;

    // The done cycle is still busy, so a start seen there is dropped too.
    assign accept     = (state == ST_IDLE) && !MMDone && MMStart;
    assign phase_last = (cnt == '0);

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        phase_entry = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = abus_q;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (MMWrite)     next_state = ST_WB;
                    else if (MMRead) next_state = ST_RD;
                    else             next_state = ST_DONE;
                end
            end
            ST_WB: begin
                ram_addr = MM_ADDR_W'(tag_q);
                // Reset arriving in the commit cycle suppresses the write.
                ram_we   = phase_last && rst_n;
                if (phase_last) next_state = read_q ? ST_RD : ST_DONE;
            end
            ST_RD: begin
                if (phase_last) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase

        phase_entry = (next_state != state) &&
                      ((next_state == ST_WB) || (next_state == ST_RD));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            MemtoCache <= '0;
            MMBusy     <= 1'b0;
            MMDone     <= 1'b0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
        end else begin
            state  <= next_state;
            MMDone <= (state == ST_DONE);
            MMBusy <= (next_state != ST_IDLE) || (state == ST_DONE);

            if (phase_entry)       cnt <= CNT_LOAD;
            else if (cnt != '0)    cnt <= cnt - 1'b1;

            if (accept) begin
                write_q <= MMWrite;
                read_q  <= MMRead;
            end

            // RAM registered the refill word on the last RD edge.
            if ((state == ST_DONE) && read_q) MemtoCache <= ram_rdata;
        end
    end

    // Request payload is held while busy; it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q   <= OldTag;
            wdata_q <= CachetoMem;
            abus_q  <= ABUS;
        end
    end

    mm_array #(
        .ADDR_W (MM_ADDR_W),
        .DATA_W (MM_DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule : main_mem_ctrl
